sum_drain: RTL and testbench
============================

# sum_drain

Read-side controller for the ping-pong partial-sum accumulator bank. After an accumulation pass completes, it flips the bank select so the freshly filled bank appears on the accumulator read port. It then walks the read address from 0 to len-1 and streams the sums out on a valid/ready interface toward the output/DDR writer. A credit-limited skid FIFO absorbs the fixed read latency so back-pressure never loses data.

## Interface
Parameters:
- C_DSIZE, 24, sum word width
- C_ASIZE, 10, accumulator address width
- C_RD_LAT, 3, cycles from O_raddr presented to I_rdata valid (accumulator read path: addr reg + RAM reg + output reg)
- C_FIFO_DEPTH, 4, skid FIFO entries; must be ≥ C_RD_LAT+1 for 1 word/clk throughput

Ports:
- I_clk  in  1  single clock; all logic on rising edge
- I_rstn  in  1  asynchronous, active-low reset
- I_start  in  1  one-cycle pulse; accepted only in IDLE
- I_len  in  C_ASIZE+1  word count to drain, sampled with I_start; 0..2^C_ASIZE
- O_busy  out  1  high from the cycle after acceptance through the O_done cycle
- O_done  out  1  one-cycle pulse when drain completes
- O_wram0_en  out  1  bank select to accumulator; 1 = write bank0/read bank1
- O_raddr  out  C_ASIZE  accumulator read address
- I_rdata  in  C_DSIZE  accumulator read data, valid C_RD_LAT cycles after the matching O_raddr
- O_tvalid  out  1  stream data valid
- I_tready  in  1  stream sink ready
- O_tdata  out  C_DSIZE  stream data
- O_tlast  out  1  high on the final beat of a drain

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE + I_start: latch I_len; toggle O_wram0_en; go to RUN, or to DONE if I_len=0.
- RUN: issue a read (O_raddr = rcnt, internal issue strobe) when fifo_count + inflight < C_FIFO_DEPTH.
  - rcnt increments on each issue.
  - After issuing read len-1: go to FLUSH, with O_raddr holding its last value.
- Issue strobe is delayed by a C_RD_LAT shift register. The delayed strobe writes I_rdata into the FIFO.
- inflight = number of strobes in the shift register. Credits guarantee the FIFO is never written when full.
- FLUSH: wait until inflight=0, the FIFO is empty and the last beat has handshaken; then go to DONE.
- DONE: O_done=1 for one cycle; O_raddr returns to 0; go to IDLE.
- FIFO is first-word-fall-through:
  - O_tvalid = !empty; O_tdata = head.
  - Pop on O_tvalid && I_tready.
  - Simultaneous push and pop at full or empty is legal; count is unchanged.
- O_tlast = O_tvalid && (beats popped so far == len-1). A beat counter of C_ASIZE+1 bits covers len = 2^C_ASIZE.
- I_start outside IDLE: ignored, no state change, no bank toggle.
- Upstream must hold the accumulator's dven low while O_busy=1. The drain does not check this.

## Timing
- Reset values: state IDLE; O_busy=0, O_done=0, O_wram0_en=1, O_raddr=0, O_tvalid=0, O_tdata=0, O_tlast=0. FIFO, inflight pipe and counters are cleared.
- Reset asserted mid-drain: everything returns to reset values immediately, remaining data is discarded, and O_wram0_en goes back to 1.
- I_start in cycle T:
  - O_wram0_en toggled and O_busy=1 from T+1.
  - First read issued in T+1.
  - First O_tvalid in T+2+C_RD_LAT (T+5 at default).
- With I_tready held at 1: one beat per clock; last beat at T+1+C_RD_LAT+len; O_done in the following cycle.
- Back-pressure:
  - Issue stalls within the same cycle that the credits run out.
  - Data is held stable while O_tvalid && !I_tready.
- I_len=0: O_done at T+1, O_busy high only in T+1, no beats, bank still toggled.

## Test plan
- Reset, then I_start with I_len=8 and I_tready=1; accumulator model returns rdata=addr+100. Required: O_wram0_en 1→0 at T+1; beats 100..107 in cycles T+5..T+12; O_tlast only on 107; O_done at T+13.
- I_len=16 with I_tready toggling 1,0,0,1 repeating. Required: all 16 values in order, no loss or duplication; FIFO count never exceeds 4; O_tdata stable while stalled.
- I_len=1024 (full address space), I_tready=1. Required: addresses 0..1023 issued, 1024 beats, O_tlast on beat 1023, no counter wrap.
- I_len=0. Required: O_done at T+1, no O_tvalid, O_wram0_en toggled.
- A second I_start pulse mid-drain, then I_rstn low for 1 cycle at beat 3 of I_len=8. Required: the second pulse is ignored; after reset, all outputs are at reset values with O_wram0_en=1, and a new drain of I_len=4 completes normally.

Source files
------------

// File: rtl/sum_drain.sv
// Read-side drain of the ping-pong accumulator bank: flips the bank, walks the read
// address and streams sums out through a credit-limited first-word-fall-through skid FIFO.
module sum_drain #(
   parameter int C_DSIZE      = 24,
   parameter int C_ASIZE      = 10,
   parameter int C_RD_LAT     = 3,
   parameter int C_FIFO_DEPTH = 4
) (
   input  logic               I_clk,
   input  logic               I_rstn,
   input  logic               I_start,
   input  logic [C_ASIZE:0]   I_len,
   output logic               O_busy,
   output logic               O_done,
   output logic               O_wram0_en,
   output logic [C_ASIZE-1:0] O_raddr,
   input  logic [C_DSIZE-1:0] I_rdata,
   output logic               O_tvalid,
   input  logic               I_tready,
   output logic [C_DSIZE-1:0] O_tdata,
   output logic               O_tlast,
   output logic [1:0]         O_dbg_state
);

   localparam int LW = C_ASIZE + 1;
   localparam int PW = (C_FIFO_DEPTH > 1) ? $clog2(C_FIFO_DEPTH) : 1;
   localparam int CW = $clog2(C_FIFO_DEPTH + 1);
   localparam int IW = $clog2(C_RD_LAT + 2);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]          state_q, state_d;
   logic [LW-1:0]       len_q, len_d;
   logic [LW-1:0]       rcnt_q, rcnt_d;
   logic [LW-1:0]       beat_q, beat_d;
   logic                wram_q, wram_d;
   logic [C_RD_LAT-1:0] pipe_q, pipe_d;
   logic [IW-1:0]       infl_q, infl_d;
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [C_DSIZE-1:0]  mem_q [C_FIFO_DEPTH];

   logic          issue, push, pop, tvalid, credit_ok;
   logic [LW-1:0] len_m1, rcnt_m1;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (int'(p) == C_FIFO_DEPTH - 1) return '0;
      return p + 1'b1;
   endfunction

   // Stream handshake: a beat transfers on a cycle where O_tvalid && I_tready; while
   // O_tvalid is high and I_tready low, O_tdata/O_tlast hold and O_tvalid never drops.
   assign tvalid = (cnt_q != '0);
   assign pop    = tvalid & I_tready;
   assign push   = pipe_q[C_RD_LAT-1];
   assign len_m1  = len_q - 1'b1;
   assign rcnt_m1 = rcnt_q - 1'b1;

   // A pop this cycle frees a slot before any read issued now can land in the FIFO.
   assign credit_ok = (int'(cnt_q) + int'(infl_q) - int'(pop)) < C_FIFO_DEPTH;

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      rcnt_d   = rcnt_q;
      wram_d   = wram_q;
      issue    = 1'b0;
      cnt_d    = cnt_q + CW'(push) - CW'(pop);
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      beat_d   = beat_q + LW'(pop);
      case (state_q)
         S_IDLE: begin
            if (I_start) begin
               len_d   = I_len;
               rcnt_d  = '0;
               beat_d  = '0;
               wram_d  = ~wram_q;
               state_d = (I_len == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (credit_ok) begin
               issue  = 1'b1;
               rcnt_d = rcnt_q + 1'b1;
               if (rcnt_q == len_m1) state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (infl_q == '0 && cnt_d == '0 && beat_d == len_q) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
      pipe_d[0] = issue;
      for (int i = 1; i < C_RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
      infl_d = infl_q + IW'(issue) - IW'(push);
   end

   always_ff @(posedge I_clk or negedge I_rstn) begin
      if (!I_rstn) begin
         state_q  <= S_IDLE;
         len_q    <= '0;
         rcnt_q   <= '0;
         beat_q   <= '0;
         wram_q   <= 1'b1;
         pipe_q   <= '0;
         infl_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         rcnt_q   <= rcnt_d;
         beat_q   <= beat_d;
         wram_q   <= wram_d;
         pipe_q   <= pipe_d;
         infl_q   <= infl_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: the head is masked whenever the FIFO is empty.
   always_ff @(posedge I_clk) begin
      if (push) mem_q[wr_ptr_q] <= I_rdata;
   end

   always_comb begin
      O_raddr = '0;
      if (state_q == S_RUN)        O_raddr = rcnt_q[C_ASIZE-1:0];
      else if (state_q == S_FLUSH) O_raddr = rcnt_m1[C_ASIZE-1:0];
   end

   assign O_busy      = (state_q != S_IDLE);
   assign O_done      = (state_q == S_DONE);
   assign O_wram0_en  = wram_q;
   assign O_tvalid    = tvalid;
   assign O_tdata     = tvalid ? mem_q[rd_ptr_q] : '0;
   assign O_tlast     = tvalid && (beat_q == len_m1);
   assign O_dbg_state = state_q;

endmodule

// File: tb/tb_sum_drain.sv
// Directed bench for sum_drain: accumulator model returns addr+100 after 3 cycles.
module tb_sum_drain;

   localparam int DW = 24;
   localparam int AW = 10;

   logic          I_clk = 1'b0;
   logic          I_rstn = 1'b0;
   logic          I_start = 1'b0;
   logic [AW:0]   I_len = '0;
   logic          O_busy, O_done, O_wram0_en, O_tvalid, O_tlast;
   logic [AW-1:0] O_raddr;
   logic [DW-1:0] I_rdata;
   logic          I_tready = 1'b1;
   logic [DW-1:0] O_tdata;
   logic [1:0]    O_dbg_state;

   sum_drain #(.C_DSIZE(DW), .C_ASIZE(AW), .C_RD_LAT(3), .C_FIFO_DEPTH(4)) dut (
      .I_clk(I_clk), .I_rstn(I_rstn), .I_start(I_start), .I_len(I_len),
      .O_busy(O_busy), .O_done(O_done), .O_wram0_en(O_wram0_en), .O_raddr(O_raddr),
      .I_rdata(I_rdata), .O_tvalid(O_tvalid), .I_tready(I_tready), .O_tdata(O_tdata),
      .O_tlast(O_tlast), .O_dbg_state(O_dbg_state)
   );

   // clock / reset / accumulator read-path model
   always #5 I_clk = ~I_clk;

   int cyc = 0;
   always @(posedge I_clk) cyc <= cyc + 1;

   logic [AW-1:0] a1, a2, a3;
   always @(posedge I_clk) begin
      a1 <= O_raddr;
      a2 <= a1;
      a3 <= a2;
   end
   assign I_rdata = DW'(a3) + DW'(100);

   // scoreboard state
   logic [DW-1:0] exp_q[$];
   int  n_chk = 0, n_fail = 0;
   int  t_start = 0, beat_idx = 0;
   bit  mon_en = 1'b0, tim_en = 1'b0, fifo_chk = 1'b0, rdy_pat = 1'b0;
   logic exp_wram = 1'b1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
      end
   endtask

   // monitor: every valid beat must match the queue head; pop on handshake
   initial forever begin
      @(negedge I_clk);
      if (mon_en && I_rstn) begin
         if (O_tvalid) begin
            if (exp_q.size() == 0) chk("extra_beat", 32'd1, 32'd0);
            else begin
               chk("tdata", 32'(O_tdata), 32'(exp_q[0]));
               chk("tlast", 32'(O_tlast), 32'(exp_q.size() == 1));
               if (I_tready) begin
                  if (tim_en) chk("beat_cyc", 32'(cyc - t_start), 32'(5 + beat_idx));
                  void'(exp_q.pop_front());
                  beat_idx++;
               end
            end
         end else chk("tlast_idle", 32'(O_tlast), 32'd0);
         if (fifo_chk) chk("fifo_le_depth", 32'(dut.cnt_q <= 4), 32'd1);
      end
   end

   // tready pattern 1,0,0,1 repeating
   initial begin
      int ph = 0;
      logic [3:0] pat = 4'b1001;
      forever begin
         @(posedge I_clk);
         #1;
         if (rdy_pat) begin
            I_tready = pat[ph % 4];
            ph++;
         end
      end
   end

   // driver tasks
   task automatic check_reset(input string tag);
      chk({tag, "_busy"},   32'(O_busy), 32'd0);
      chk({tag, "_done"},   32'(O_done), 32'd0);
      chk({tag, "_wram"},   32'(O_wram0_en), 32'd1);
      chk({tag, "_raddr"},  32'(O_raddr), 32'd0);
      chk({tag, "_tvalid"}, 32'(O_tvalid), 32'd0);
      chk({tag, "_tdata"},  32'(O_tdata), 32'd0);
      chk({tag, "_tlast"},  32'(O_tlast), 32'd0);
   endtask

   task automatic start_drain(input int len);
      exp_q.delete();
      for (int i = 0; i < len; i++) exp_q.push_back(DW'(100 + i));
      beat_idx = 0;
      @(posedge I_clk);
      #1;
      I_start = 1'b1;
      I_len   = 11'(len);
      t_start = cyc;
      chk("wram_pre", 32'(O_wram0_en), 32'(exp_wram));
      exp_wram = ~exp_wram;
      @(posedge I_clk);
      #1;
      I_start = 1'b0;
      chk("wram_post", 32'(O_wram0_en), 32'(exp_wram));
      chk("busy_t1", 32'(O_busy), 32'd1);
   endtask

   task automatic wait_done(input int budget, input int exp_lat);
      int n = 0;
      while (!O_done && n < budget) begin
         @(posedge I_clk);
         #1;
         n++;
      end
      if (!O_done) chk("done_timeout", 32'd0, 32'd1);
      else if (exp_lat >= 0) chk("done_cyc", 32'(cyc - t_start), 32'(exp_lat));
      chk("drained", 32'(exp_q.size()), 32'd0);
      @(posedge I_clk);
      #1;
      chk("busy_after", 32'(O_busy), 32'd0);
      chk("raddr_after", 32'(O_raddr), 32'd0);
   endtask

   initial begin
      #12;
      check_reset("rst");
      @(posedge I_clk);
      #1;
      I_rstn = 1'b1;
      mon_en = 1'b1;

      // len 8, full-rate sink, exact cycle timing
      tim_en = 1'b1;
      start_drain(8);
      wait_done(40, 13);
      tim_en = 1'b0;

      // len 16 under 1,0,0,1 back-pressure
      fifo_chk = 1'b1;
      rdy_pat  = 1'b1;
      start_drain(16);
      wait_done(200, -1);
      rdy_pat  = 1'b0;
      fifo_chk = 1'b0;
      @(posedge I_clk);
      #2;
      I_tready = 1'b1;

      // full address space
      start_drain(1024);
      wait_done(1200, 1029);

      // zero length
      start_drain(0);
      chk("len0_done", 32'(O_done), 32'd1);
      chk("len0_tvalid", 32'(O_tvalid), 32'd0);
      wait_done(4, 1);

      // ignored restart, then reset at beat 3
      start_drain(8);
      I_start = 1'b1;
      I_len   = 11'd5;
      @(posedge I_clk);
      #1;
      I_start = 1'b0;
      chk("ign_wram", 32'(O_wram0_en), 32'(exp_wram));
      chk("ign_busy", 32'(O_busy), 32'd1);
      begin
         int n = 0;
         while (beat_idx < 3 && n < 40) begin
            @(posedge I_clk);
            #1;
            n++;
         end
         chk("reach_beat3", 32'(beat_idx >= 3), 32'd1);
      end
      mon_en = 1'b0;
      I_rstn = 1'b0;
      #1;
      check_reset("midrst");
      @(posedge I_clk);
      #1;
      I_rstn = 1'b1;
      exp_wram = 1'b1;
      exp_q.delete();
      mon_en = 1'b1;
      tim_en = 1'b1;
      start_drain(4);
      wait_done(30, 9);
      tim_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
